// File: rtl/iram_arbiter.sv
// iram_arbiter: shares the single-ported instruction RAM between the fetch
// port and the load/store port. Each request is range- and alignment-checked
// and then run as a one-cycle RAM transaction. The result comes back as a
// registered ready pulse with rdata/err. Data accesses have priority, and a
// streak limit stops fetch from starving.
module iram_arbiter #(
   parameter logic [63:0] RAM_START       = 64'h0,
   parameter int          RAM_SIZE        = 256,
   parameter int          MAX_DATA_STREAK = 4
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        i_req,
   input  logic [63:0] i_addr,
   output logic        i_ready,
   output logic [63:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   input  logic        d_write,
   output logic        d_ready,
   output logic [63:0] d_rdata,
   output logic        d_err,
   output logic [63:0] HADDR,
   output logic [63:0] HWDATA,
   output logic        HWRITE,
   input  logic [63:0] HRDATA
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   // The range check uses the offset from the window base. Addresses below
   // the base wrap to huge offsets, so a single unsigned compare covers
   // both ends of the window.
   localparam logic [63:0] LAST_OFF   = 64'(RAM_SIZE - 4);
   localparam logic [3:0]  STREAK_MAX = 4'(MAX_DATA_STREAK);

   logic [1:0]  state;
   logic [3:0]  streak;
   logic [63:0] addr_q;
   logic [31:0] wdata_q;
   logic        write_q;
   logic        gnt_d;

   logic        any_req;
   logic        pick_d;
   logic [63:0] req_addr;
   logic [63:0] req_off;
   logic        req_bad;

   // Only the low word of store data and RAM read data is meaningful.
   logic        unused_hi;
   assign unused_hi = ^{d_wdata[63:32], HRDATA[63:32]};

   // Arbitration and request check. Data wins unless fetch is waiting and the
   // streak limit has been reached.
   always_comb begin
      any_req  = i_req | d_req;
      pick_d   = d_req && (!i_req || (streak != STREAK_MAX));
      req_addr = pick_d ? d_addr : i_addr;
      req_off  = req_addr - RAM_START;
      req_bad  = (req_off > LAST_OFF) || (req_addr[1:0] != 2'b00);
   end

   // The RAM bus is driven only in ACCESS and only from latched state, so it
   // has no combinational path from the request inputs.
   always_comb begin
      HADDR  = 64'd0;
      HWDATA = 64'd0;
      HWRITE = 1'b0;
      if (state == ACCESS) begin
         HADDR  = addr_q;
         HWDATA = {32'd0, wdata_q};
         HWRITE = write_q;
      end
   end

   // Streak of data grants that happened while fetch was waiting. Any grant
   // with fetch idle, or any fetch grant, clears it.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         streak <= 4'd0;
      end else if (state == IDLE && any_req) begin
         if (!pick_d || !i_req)
            streak <= 4'd0;
         else if (streak != STREAK_MAX)
            streak <= streak + 4'd1;
      end
   end

   // Sequencer: IDLE grants and latches; ACCESS runs the RAM cycle; DONE
   // holds the registered ready pulse. An illegal request skips ACCESS.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state   <= IDLE;
         addr_q  <= 64'd0;
         wdata_q <= 32'd0;
         write_q <= 1'b0;
         gnt_d   <= 1'b0;
         i_ready <= 1'b0;
         i_rdata <= 64'd0;
         i_err   <= 1'b0;
         d_ready <= 1'b0;
         d_rdata <= 64'd0;
         d_err   <= 1'b0;
      end else begin
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  addr_q  <= req_addr;
                  wdata_q <= pick_d ? d_wdata[31:0] : 32'd0;
                  write_q <= pick_d & d_write;
                  gnt_d   <= pick_d;
                  if (req_bad) begin
                     state <= DONE;
                     if (pick_d) begin
                        d_ready <= 1'b1;
                        d_err   <= 1'b1;
                        d_rdata <= 64'd0;
                     end else begin
                        i_ready <= 1'b1;
                        i_err   <= 1'b1;
                        i_rdata <= 64'd0;
                     end
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               state <= DONE;
               if (gnt_d) begin
                  d_ready <= 1'b1;
                  d_err   <= 1'b0;
                  d_rdata <= write_q ? 64'd0 : {32'd0, HRDATA[31:0]};
               end else begin
                  i_ready <= 1'b1;
                  i_err   <= 1'b0;
                  i_rdata <= {32'd0, HRDATA[31:0]};
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/iram_arbiter.md
# iram_arbiter

Two-requester arbiter and access sequencer in front of the single-ported instruction RAM. It shares the RAM between the core's instruction-fetch port and its load/store port, which both target the same memory. It serialises their accesses into one-cycle RAM transactions, range- and alignment-checks each request, and returns registered read data with a ready pulse. Data accesses have priority, and a streak limit keeps fetch from starving.

## Interface
Parameters:
- RAM_START, 64'h0, base byte address of the RAM window
- RAM_SIZE, 256, RAM size in bytes; the last legal word address is RAM_START+RAM_SIZE-4
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch is waiting (1..15)

Ports:
- HCLK  in  1  single clock; all state changes on its rising edge
- HRESETn  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request; held with i_addr until i_ready
- i_addr  in  64  fetch byte address
- i_ready  out  1  one-cycle completion pulse for fetch
- i_rdata  out  64  fetch data {32'd0, word}; valid while i_ready=1
- i_err  out  1  fetch error; valid while i_ready=1
- d_req  in  1  data request; held with d_addr, d_wdata, d_write until d_ready
- d_addr  in  64  data byte address
- d_wdata  in  64  store data; only [31:0] is written
- d_write  in  1  1 = store, 0 = load
- d_ready  out  1  one-cycle completion pulse for data
- d_rdata  out  64  load data {32'd0, word}; 0 for stores; valid while d_ready=1
- d_err  out  1  data error; valid while d_ready=1
- HADDR  out  64  RAM address
- HWDATA  out  64  RAM write data {32'd0, d_wdata[31:0]}
- HWRITE  out  1  RAM write strobe
- HRDATA  in  64  RAM read data, combinational from HADDR

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE:** if any request is pending, the arbiter grants one of them. The granted requester's address, write data, write flag and identity are latched.
  - Legal request: next state is ACCESS.
  - Illegal request: next state is DONE with err=1 and no RAM access.
  - No request: the FSM stays in IDLE.
- **Illegal request:** address < RAM_START, address > RAM_START+RAM_SIZE-4, or addr[1:0] != 0.
- **Arbitration when both requests are pending:**
  - Data wins, unless streak == MAX_DATA_STREAK; then fetch wins.
  - Only one pending: that requester wins.
- **Streak counter** (4 bits):
  - +1 on each data grant while i_req=1, saturating at MAX_DATA_STREAK.
  - Cleared on a fetch grant.
  - Cleared on a data grant while i_req=0.
- **ACCESS:**
  - HADDR = latched address.
  - HWRITE = latched write flag, asserted for this cycle only.
  - HWDATA = {32'd0, latched wdata[31:0]}.
  - For a load or fetch, {32'd0, HRDATA[31:0]} is registered into rdata at the end of the cycle.
  - Next state is DONE.
- **DONE:**
  - The granted port's ready is 1; its rdata and err are registered outputs.
  - The other port's ready is 0.
  - Next state is IDLE, unconditionally.
- **Outside ACCESS:** HADDR=0, HWDATA=0, HWRITE=0.
- **Latching:** request inputs are latched at grant; later changes to them are ignored for that transaction.
- **req dropped early:** if req drops before ready, the transaction still completes and the ready pulse is still issued.
- **Fixed rdata/err values:**
  - Store: rdata=0.
  - Error: rdata=0, err=1.
  - Legal access: err=0.
- **Reset** (HRESETn=0 sampled at a rising edge), effective after that edge:
  - state=IDLE, streak=0.
  - i_ready, d_ready, i_err, d_err = 0.
  - i_rdata, d_rdata = 0.
  - HADDR=0, HWDATA=0, HWRITE=0.
- **Reset mid-operation:** an in-flight access is abandoned, no ready is issued, and HWRITE is 0 from the first cycle after the reset edge.

## Timing
- **Legal access:** req sampled high at edge E0; ACCESS occupies cycle E0→E1; ready=1 during cycle E1→E2. Latency is 2 cycles from the sampling edge.
- **Illegal access:** ready+err during cycle E0→E1. Latency is 1 cycle.
- **Throughput:** one legal access per 3 cycles, because DONE always returns to IDLE. A requester holding req through the ready pulse is not re-granted until IDLE samples it again, 1 cycle after ready.
- **Back-to-back requests:** the requester must drop req at the edge ending ready, or present a new request. A req still high in IDLE is treated as a new request.
- **Outputs:** ready, rdata and err are registered. HADDR, HWDATA and HWRITE are decoded from state and latched registers, with no combinational path from request inputs.

## Test plan
- **Reset:** hold HRESETn=0 for 2 cycles with i_req=d_req=1 → all outputs 0, no ACCESS cycle; first ACCESS appears 1 cycle after release.
- **Fetch:** RAM preloaded with bytes 0..3 = 83 30 80 01. Fetch at addr 0 → HADDR=0 in ACCESS; i_ready pulse 2 cycles after sampling with i_rdata=64'h0000_0000_0180_3083, i_err=0.
- **Load:** RAM bytes 24..27 hold 0x18..0x1B. Data load at 24 → d_rdata=64'h0000_0000_1B1A_1918. Store of 64'hFFFF_FFFF_DEAD_BEEF to 32 → HWRITE=1 for exactly 1 cycle with HWDATA=64'h0000_0000_DEAD_BEEF; a following load at 32 returns 64'h0000_0000_DEAD_BEEF.
- **Arbitration:** i_req and d_req both held continuously with MAX_DATA_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I. With i_req=0, data is granted indefinitely and the streak stays 0.
- **Illegal requests:**
  - Fetch at 253 → i_ready+i_err in the next cycle, i_rdata=0, HWRITE never asserted.
  - Store at 0x102 → d_err=1, RAM unchanged.
  - Load at 6 (misaligned) → d_err=1.
- **Reset during a store's ACCESS cycle:** HWRITE=0 from the next cycle, no d_ready pulse, FSM in IDLE.
